mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the E-stage MDU control (MDUOp, Start) produced by the decoder.
- Holds the architectural HI/LO registers and runs multi-cycle MULT/MULTU/DIV/DIVU.
- Reports Busy to the hazard unit, which stalls any D-stage MDU-class instruction while Start|Busy.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU
DIV_CYCLES, 10, busy cycles for DIV/DIVU

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
Start  input  1  E-stage MULT/MULTU/DIV/DIVU launch pulse
MDUOp  input  4  operation code (MDU_* constants)
A  input  32  rs operand (forwarded)
B  input  32  rt operand (forwarded)
Req  input  1  exception/interrupt request; E-stage instruction is being flushed
Busy  output  1  operation in progress
HI  output  32  current HI register
LO  output  32  current LO register
Out  output  32  MFHI→HI, MFLO→LO, otherwise 0 (combinational)

Behaviour:
- One clock; reset is synchronous and active-high on clk/reset.
- Reset: HI=0, LO=0, Busy=0, state IDLE, counter 0, temp result regs 0. Reset overrides everything, including mid-operation; the in-flight result is discarded.
- States: IDLE, RUN.
- IDLE→RUN when Start=1 & Req=0 & MDUOp∈{MULT,MULTU,DIV,DIVU}:
  - counter loads MULT_CYCLES or DIV_CYCLES.
  - The result is computed from A/B sampled at that edge and stored in tempHI/tempLO. Later operand changes have no effect.
- RUN: counter decrements each edge. On the edge where counter==1: HI<=tempHI, LO<=tempLO, state→IDLE.
- Busy = (state==RUN).
- Timing: Start sampled at edge T0 → Busy=1 for exactly MULT_CYCLES (DIV_CYCLES) cycles → HI/LO updated and Busy=0 at edge T0+MULT_CYCLES. New values are visible on HI/LO/Out from that edge on.
- Arithmetic:
  - MULT: signed 32×32→64; MULTU: unsigned. HI = upper 32 bits, LO = lower 32 bits.
  - DIV: signed; quotient truncates toward zero, remainder takes the sign of the dividend. LO = quotient, HI = remainder.
  - DIVU: unsigned.
  - Divide by zero (B==0): operation still runs full DIV_CYCLES with Busy; HI/LO are left unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: in IDLE with Req=0, HI<=A (or LO<=A) at the next edge. No busy period.
- Req=1: Start, MTHI and MTLO are ignored that cycle. An already-running operation is not aborted and commits normally.
- Start, MTHI or MTLO arriving while in RUN: illegal (hazard unit prevents it). Required response: ignored. Busy and the in-flight result are unaffected.
- MFHI/MFLO: Out reflects the current registers combinationally. No state change.
- MDUOp=0 or any other code: no effect.

Decomposition:
- MDU_* opcode constants go in the shared macro include, alongside the ALU_/Mem_ constants: MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6, MDU_MFHI=7, MDU_MFLO=8.
- State encodings are local to the block.
- No sub-module is required: the datapath is behavioural * / %, with a result latch plus counter FSM.

Test Plan:
1. MULT with A=0xFFFFFFFD (−3), B=7 → Busy=1 for 5 cycles; after the 5th edge HI=0xFFFFFFFF, LO=0xFFFFFFEB, Busy=0.
2. MULTU with A=0xFFFFFFFF, B=2 → HI=1, LO=0xFFFFFFFE after 5 cycles. Changing A/B during Busy does not alter the result.
3. DIV with A=0xFFFFFFF9 (−7), B=2 → 10 Busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU with A=7, B=0 → 10 Busy cycles, HI/LO unchanged.
4. MTHI A=0x12345678, then MFLO/MFHI → HI=0x12345678 at the next edge, Out=0x12345678 on MFHI, Busy never asserts. MTLO with Req=1 → LO unchanged.
5. Start DIV with Req=1 → Busy stays 0, HI/LO unchanged. Start MULT, then assert Req during RUN → operation still commits at cycle 5.
6. Start DIV, assert reset at Busy cycle 4 → next edge HI=LO=0, Busy=0. No later commit occurs.

Source files
------------

// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg: shared MDU operation codes and small decode helpers.
//   MDU_* : 4-bit operation codes carried on MDUOp from the decoder.
//   mdu_is_start : true for codes that launch a multi-cycle operation.
//   mdu_is_div   : true for the two divide codes.
package mdu_unit_pkg;

    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MFHI  = 4'd7;
    localparam logic [3:0] MDU_MFLO  = 4'd8;

    function automatic logic mdu_is_start(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit holding the HI/LO registers.
//   clk, reset : clock and synchronous active-high reset
//   Start      : launch pulse for MULT/MULTU/DIV/DIVU
//   MDUOp      : operation code (MDU_* from mdu_unit_pkg)
//   A, B       : forwarded rs/rt operands
//   Req        : E-stage instruction is being flushed; new work is ignored
//   Busy       : a multi-cycle operation is in flight
//   HI, LO     : architectural HI/LO registers
//   Out        : HI on MFHI, LO on MFLO, otherwise 0 (combinational)
// The result is computed at launch and held in a temp latch; a counter
// models the architectural latency and commits the latch when it expires.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [31:0]        hi_reg, hi_next;
    logic [31:0]        lo_reg, lo_next;
    logic [31:0]        temp_hi_reg, temp_hi_next;
    logic [31:0]        temp_lo_reg, temp_lo_next;
    logic               skip_reg, skip_next;   // divide by zero: commit nothing

    // Combinational result of the operation currently on MDUOp/A/B.
    logic [63:0]        prod_s, prod_u;
    logic signed [31:0] a_s, b_s;
    logic [31:0]        res_hi, res_lo;

    assign a_s    = A;
    assign b_s    = B;
    // Sign-extending to 64 bits makes the plain 64-bit product the signed one.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (MDUOp)
            MDU_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MDU_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MDU_DIV: begin
                if (B == 32'd0) begin
                    res_hi = 32'd0;
                    res_lo = 32'd0;
                end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                    // Overflow case: quotient wraps to the dividend.
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_lo = a_s / b_s;
                    res_hi = a_s % b_s;
                end
            end
            MDU_DIVU: begin
                if (B != 32'd0) begin
                    res_lo = A / B;
                    res_hi = A % B;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        temp_hi_next = temp_hi_reg;
        temp_lo_next = temp_lo_reg;
        skip_next    = skip_reg;
        case (state_reg)
            IDLE: begin
                if (!Req) begin
                    if (Start && mdu_is_start(MDUOp)) begin
                        state_next   = RUN;
                        count_next   = mdu_is_div(MDUOp) ? CNT_W'(DIV_CYCLES)
                                                         : CNT_W'(MULT_CYCLES);
                        temp_hi_next = res_hi;
                        temp_lo_next = res_lo;
                        skip_next    = mdu_is_div(MDUOp) && (B == 32'd0);
                    end else if (MDUOp == MDU_MTHI) begin
                        hi_next = A;
                    end else if (MDUOp == MDU_MTLO) begin
                        lo_next = A;
                    end
                end
            end
            RUN: begin
                // New Start/MTHI/MTLO are ignored here; Req does not abort.
                count_next = count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                    if (!skip_reg) begin
                        hi_next = temp_hi_reg;
                        lo_next = temp_lo_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            temp_hi_reg <= 32'd0;
            temp_lo_reg <= 32'd0;
            skip_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            temp_hi_reg <= temp_hi_next;
            temp_lo_reg <= temp_lo_next;
            skip_reg    <= skip_next;
        end
    end

    assign Busy = (state_reg == RUN);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

    always_comb begin
        Out = 32'd0;
        if (MDUOp == MDU_MFHI)      Out = hi_reg;
        else if (MDUOp == MDU_MFLO) Out = lo_reg;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: scoreboard bench for mdu_unit. Expected HI/LO/latency are
// pushed when an operation is launched and popped when Busy drops.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk, reset, Start, Req, Busy;
    logic [3:0]  MDUOp;
    logic [31:0] A, B, HI, LO, Out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        logic [3:0]  op;
    } exp_t;

    exp_t sb_q[$];

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp),
        .A(A), .B(B), .Req(Req), .Busy(Busy), .HI(HI), .LO(LO), .Out(Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model built from the unsigned product/quotient with sign fixes.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        logic [31:0] ua, ub, q, r;
        hi = model_hi;
        lo = model_lo;
        p  = {32'd0, a} * {32'd0, b};
        case (op)
            MDU_MULTU: begin hi = p[63:32]; lo = p[31:0]; end
            MDU_MULT: begin
                hi = p[63:32] - (a[31] ? b : 32'd0) - (b[31] ? a : 32'd0);
                lo = p[31:0];
            end
            MDU_DIVU: if (b != 0) begin lo = a / b; hi = a % b; end
            MDU_DIV: if (b != 0) begin
                ua = a[31] ? (~a + 32'd1) : a;
                ub = b[31] ? (~b + 32'd1) : b;
                q  = ua / ub;
                r  = ua % ub;
                lo = (a[31] ^ b[31]) ? (~q + 32'd1) : q;
                hi = a[31] ? (~r + 32'd1) : r;
            end
            default: ;
        endcase
    endtask

    // Launch an op; optionally hold Req during RUN and inject an illegal
    // op (ill_op) at busy cycle 2. Operands are scrambled after launch.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit req_mid, input logic [3:0] ill_op);
        exp_t e, g;
        int   busy_n;
        model(op, a, b, e.hi, e.lo);
        e.cycles = mdu_is_div(op) ? DC : MC;
        e.op     = op;
        sb_q.push_back(e);
        Start = 1'b1; MDUOp = op; A = a; B = b;
        step();
        Start = 1'b0; MDUOp = 4'd0; A = $urandom; B = $urandom;
        busy_n = 0;
        while (Busy && busy_n < 64) begin
            busy_n++;
            Req = req_mid;
            if (busy_n == 2 && ill_op != 4'd0) begin
                Start = 1'b1; MDUOp = ill_op; A = 32'hDEAD_0000; B = 32'd3;
            end else begin
                Start = 1'b0; MDUOp = 4'd0;
            end
            step();
        end
        Start = 1'b0; MDUOp = 4'd0; Req = 1'b0;
        g = sb_q.pop_front();
        chk("busy_cycles", 32'(busy_n), 32'(g.cycles));
        chk("hi", HI, g.hi);
        chk("lo", LO, g.lo);
        model_hi = g.hi;
        model_lo = g.lo;
        $display("op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", op, a, b, busy_n, HI, LO);
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; Req = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
        step(); step();
        reset = 1'b0;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_out", Out, 32'd0);

        launch(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 4'd0);
        chk("t1_hi_const", HI, 32'hFFFF_FFFF);
        chk("t1_lo_const", LO, 32'hFFFF_FFEB);

        launch(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, MDU_DIV);
        chk("t2_hi_const", HI, 32'd1);
        chk("t2_lo_const", LO, 32'hFFFF_FFFE);

        launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 4'd0);
        chk("t3_lo_const", LO, 32'hFFFF_FFFD);
        chk("t3_hi_const", HI, 32'hFFFF_FFFF);

        launch(MDU_DIVU, 32'd7, 32'd0, 1'b0, MDU_MTHI);
        chk("divz_hi_const", HI, 32'hFFFF_FFFF);
        chk("divz_lo_const", LO, 32'hFFFF_FFFD);

        launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 4'd0);
        chk("ovf_lo_const", LO, 32'h8000_0000);
        chk("ovf_hi_const", HI, 32'd0);

        for (int i = 0; i < 6; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(1, 4));
            launch(op, $urandom, (i == 3) ? 32'd13 : $urandom, 1'b0, 4'd0);
        end

        // MTHI / MFHI / MFLO
        MDUOp = MDU_MTHI; A = 32'h1234_5678;
        step();
        chk("mthi_busy", {31'd0, Busy}, 32'd0);
        chk("mthi_hi", HI, 32'h1234_5678);
        model_hi = 32'h1234_5678;
        MDUOp = MDU_MFHI; #1;
        chk("mfhi_out", Out, 32'h1234_5678);
        MDUOp = MDU_MFLO; #1;
        chk("mflo_out", Out, model_lo);
        MDUOp = 4'd9; #1;
        chk("other_out", Out, 32'd0);
        MDUOp = MDU_MTLO; A = 32'hCAFE_F00D; Req = 1'b1;
        step();
        chk("mtlo_req_lo", LO, model_lo);
        Req = 1'b0;
        step();
        chk("mtlo_lo", LO, 32'hCAFE_F00D);
        model_lo = 32'hCAFE_F00D;
        MDUOp = 4'd0;
        $display("mt: hi=%h lo=%h", HI, LO);

        // Start with Req is ignored
        Start = 1'b1; MDUOp = MDU_DIV; A = 32'd100; B = 32'd3; Req = 1'b1;
        step();
        Start = 1'b0; MDUOp = 4'd0; Req = 1'b0;
        chk("req_busy", {31'd0, Busy}, 32'd0);
        repeat (DC + 1) step();
        chk("req_hi", HI, model_hi);
        chk("req_lo", LO, model_lo);
        $display("start_with_req: busy=%0d hi=%h lo=%h", Busy, HI, LO);

        launch(MDU_MULT, 32'd1000, 32'hFFFF_FF00, 1'b1, 4'd0);

        // Reset in the middle of a divide
        Start = 1'b1; MDUOp = MDU_DIV; A = 32'd100; B = 32'd7;
        step();
        Start = 1'b0; MDUOp = 4'd0;
        repeat (3) step();
        chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
        chk("mid_rst_hi", HI, 32'd0);
        chk("mid_rst_lo", LO, 32'd0);
        repeat (DC + 2) step();
        chk("post_rst_hi", HI, 32'd0);
        chk("post_rst_lo", LO, 32'd0);
        chk("post_rst_busy", {31'd0, Busy}, 32'd0);
        $display("mid_reset: busy=%0d hi=%h lo=%h", Busy, HI, LO);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
